dmem_unit: RTL and testbench
============================

Name: dmem_unit

Overview:
- Parametrised data-memory unit for the pipelined CPU: byte-lane RAM, store byte-enable generation and load extraction/extension in one block.
- Generalises the data path to DATA_W = 32 or 64 and to any depth.
- Adds synchronous registered read, a valid/ready request/response handshake with backpressure, and misalignment detection.
- Sits in the MEM stage; the core issues one request per cycle and consumes responses in order.

Parameters:
ADDR_W, 13, byte-address width; memory holds 2**(ADDR_W-OFF_W) words
DATA_W, 32, word width; legal values 32 or 64; NB = DATA_W/8 lanes, OFF_W = log2(NB)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when high with req_valid
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address
req_size  input  2  00 byte, 01 half, 10 word, 11 dword
req_signed  input  1  loads: sign-extend (1) or zero-extend (0)
req_wdata  input  DATA_W  store data, right-aligned (low bits)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned or illegal size

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=1 in the cycle after reset.
  - Memory contents are not reset.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (combinational).
  - Accept = req_valid && req_ready.
  - Response is registered: rsp_valid=1 on the cycle after accept, held stable until rsp_ready.
  - Throughput is one request per cycle when rsp_ready=1; latency is 1 cycle.
- Two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY->FULL on accept.
  - FULL->EMPTY on rsp_ready without accept.
  - FULL->FULL on rsp_ready with accept, loading the new response.
- Address split: word index = req_addr[ADDR_W-1:OFF_W]; offset = req_addr[OFF_W-1:0].
- Error checks (err=1):
  - Size bytes exceed NB (dword with DATA_W=32).
  - Offset not a multiple of the size in bytes.
- Error handling: no memory write, rsp_err=1, rsp_rdata=0. The error takes a normal response slot.
- Stores:
  - Byte mask = (2**size_bytes - 1) << offset.
  - Store data is replicated into lanes: lane k gets byte ((k - offset) mod size_bytes) of req_wdata.
  - Write occurs on the accept edge; unmasked lanes are untouched.
  - Response: rdata=0, err=0.
- Loads:
  - The word is read on the accept edge into a register; offset, size and signed are registered alongside.
  - rsp_rdata selects bytes [offset, offset+size_bytes) from the registered word, right-aligned, then zero- or sign-extended to DATA_W.
  - Full-width load returns the word unmodified.
- Ordering:
  - A store accepted in cycle N is visible to a load accepted in cycle N+1 or later, to the same or any address.
  - No same-cycle conflict exists: one request per cycle.
- Reset mid-operation: a pending response is dropped (rsp_valid=0 next cycle). Stores already accepted remain in memory.
- Inputs are ignored while req_ready=0. Registered response fields must not change while rsp_valid && !rsp_ready.

Decomposition:
- Package dmem_pkg:
  - Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - Function size_bytes(size).
  - Function lane_mask(size, offset, NB).
  - Function load_extend(word, offset, size, signed).
- Sub-module bram_be:
  - Parameters: depth and lane count.
  - Per-lane write enable, registered read.
- dmem_unit: handshake, error check, store lane replication and load extension.

Test Plan:
- DATA_W=32, lane extraction: sw 0x80FF7F01 @0x20, then loads @0x20/0x22/0x23.
  - lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080.
  - lh 0x22 -> 0xFFFF80FF; lhu 0x20 -> 0x00007F01.
  - All with err=0, one cycle after accept.
- Partial stores: after the above, sb 0xAB @0x21 -> lw 0x20 = 0x80FFAB01; then sh 0xBEEF @0x22 -> lw 0x20 = 0xBEEFAB01.
- Errors:
  - lh @0x23 -> err=1, rdata=0.
  - sw @0x22 -> err=1, and a later lw 0x20 is still 0xBEEFAB01.
  - size=11 with DATA_W=32 -> err=1.
- Backpressure: 4 back-to-back loads, rsp_ready=0 for 3 cycles after the first response.
  - req_ready=0 during the stall.
  - rsp_rdata/rsp_err held stable.
  - Exactly 4 responses, in order, no duplicates.
- Reset mid-operation: assert rst with rsp_valid=1 and rsp_ready=0.
  - Next cycle rsp_valid=0, req_ready=1.
  - lw of a previously stored word returns the stored value.
- DATA_W=64: sd 0x0123456789ABCDEF @0x08.
  - lw signed @0x08 -> 0xFFFFFFFF89ABCDEF.
  - lw @0x0C -> 0x0000000001234567.
  - lbu @0x0F -> 0x01.
  - ld @0x0C -> err=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory.
// Size codes, lane masks and load extraction used by dmem_unit.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        EMPTY,
        FULL
    } rsp_state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    function automatic logic [7:0] lane_mask(
        input logic [1:0] size,
        input logic [2:0] offset,
        input int         nb
    );
        logic [7:0] m;
        m = 8'((9'd1 << size_bytes(size)) - 9'd1);
        return (m << offset) & 8'((1 << nb) - 1);
    endfunction

    // Right-align the addressed bytes, then widen to 64 bits.
    function automatic logic [63:0] load_extend(
        input logic [63:0] word,
        input logic [2:0]  offset,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [63:0] s;
        s = word >> {offset, 3'b000};
        unique case (size)
            SZ_B: s = {{56{sgn & s[7]}}, s[7:0]};
            SZ_H: s = {{48{sgn & s[15]}}, s[15:0]};
            SZ_W: s = {{32{sgn & s[31]}}, s[31:0]};
            SZ_D: s = s;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dmem_unit_bram.sv
// Byte-lane RAM: per-lane write enable, registered read port.
// Contents are intentionally not reset.
module bram_be #(
    parameter int DEPTH = 2048,
    parameter int NB    = 4,
    parameter int AW    = 11
) (
    input  logic            clk,
    input  logic [NB-1:0]   we,
    input  logic            re,
    input  logic [AW-1:0]   addr,
    input  logic [NB*8-1:0] wdata,
    output logic [NB*8-1:0] rdata
);

    logic [NB*8-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (we[k]) mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_unit.sv
// MEM-stage data memory: valid/ready request, registered response,
// store lane replication, load extension and misalignment errors.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = ADDR_W - OFF_W;

    rsp_state_t        state_q, state_d;
    logic              accept, err, go, ld_en;
    logic [OFF_W-1:0]  off, off_q;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        sbytes;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wlanes, word;
    logic              ld_q, err_q, sgn_q;
    logic [1:0]        size_q;

    assign idx    = req_addr[ADDR_W-1:OFF_W];
    assign off    = req_addr[OFF_W-1:0];
    assign sbytes = size_bytes(req_size);
    assign err    = (sbytes > 4'(NB))
                 || ((off & OFF_W'(sbytes - 4'd1)) != '0);

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign go        = accept && !rst && !err;
    assign ld_en     = go && !req_we;
    assign be        = (go && req_we)
                     ? NB'(lane_mask(req_size, 3'(off), NB)) : '0;

    // Lane k takes byte (k - offset) mod size of the right-aligned data.
    always_comb begin
        wlanes = '0;
        for (int k = 0; k < NB; k++) begin
            logic [OFF_W-1:0] sel;
            sel = (OFF_W'(k) - off) & OFF_W'(sbytes - 4'd1);
            wlanes[k*8 +: 8] = req_wdata[sel*8 +: 8];
        end
    end

    bram_be #(
        .DEPTH (1 << IDX_W),
        .NB    (NB),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (be),
        .re    (ld_en),
        .addr  (idx),
        .wdata (wlanes),
        .rdata (word)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (rsp_ready && !accept) state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q   <= 1'b0;
            err_q  <= 1'b0;
            sgn_q  <= 1'b0;
            size_q <= SZ_B;
            off_q  <= '0;
        end else if (accept) begin
            ld_q   <= !req_we && !err;
            err_q  <= err;
            sgn_q  <= req_signed;
            size_q <= req_size;
            off_q  <= off;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && ld_q)
        ? DATA_W'(load_extend(64'(word), 3'(off_q), size_q, sgn_q))
        : '0;

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: 32- and 64-bit instances checked
// against a byte-array reference model with random backpressure.
module tb_dmem_unit;

    localparam int AW = 13;

    typedef struct {
        logic        err;
        logic [63:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]         req_valid = '0;
    logic [1:0]         req_we = '0;
    logic [1:0]         req_signed = '0;
    logic [1:0]         rsp_ready = '0;
    logic [1:0][AW-1:0] req_addr = '0;
    logic [1:0][1:0]    req_size = '0;
    logic [1:0][63:0]   req_wdata = '0;

    logic rr0, rr1, rv0, rv1, re0, re1;
    logic [31:0] rdata32;
    logic [63:0] rdata64;
    logic [1:0]  req_ready, rsp_valid, rsp_err;
    logic [1:0][63:0] rd;

    assign req_ready = {rr1, rr0};
    assign rsp_valid = {rv1, rv0};
    assign rsp_err   = {re1, re0};
    assign rd[0]     = {32'h0, rdata32};
    assign rd[1]     = rdata64;

    dmem_unit #(.ADDR_W(AW), .DATA_W(32)) u_d32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(rr0),
        .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_size(req_size[0]), .req_signed(req_signed[0]),
        .req_wdata(req_wdata[0][31:0]),
        .rsp_valid(rv0), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rdata32), .rsp_err(re0)
    );

    dmem_unit #(.ADDR_W(AW), .DATA_W(64)) u_d64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(rr1),
        .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_size(req_size[1]), .req_signed(req_signed[1]),
        .req_wdata(req_wdata[1]),
        .rsp_valid(rv1), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rdata64), .rsp_err(re1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    rsp_t q0[$];
    rsp_t q1[$];
    logic [7:0] mem [2][64];

    // rsp_ready policy per DUT: 0 ready, 1 random, 2 held low
    int          mode[2] = '{2, 2};
    int          stall_n[2] = '{0, 0};
    bit          arm[2] = '{0, 0};
    bit          held[2] = '{0, 0};
    logic        perr[2];
    logic [63:0] pdat[2];
    bit          quiet = 1'b0;

    function automatic int qsize(input int d);
        return d ? q1.size() : q0.size();
    endfunction

    function automatic rsp_t qpop(input int d);
        if (d != 0) return q1.pop_front();
        return q0.pop_front();
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        rsp_t e;
        for (int d = 0; d < 2; d++) begin
            if (arm[d] && rsp_valid[d]) begin
                stall_n[d] = 3;
                arm[d] = 1'b0;
            end
            if (stall_n[d] > 0) begin
                rsp_ready[d] = 1'b0;
                stall_n[d]--;
            end else if (mode[d] == 0) rsp_ready[d] = 1'b1;
            else if (mode[d] == 1) rsp_ready[d] = 1'($urandom_range(0, 1));
            else rsp_ready[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst || quiet) begin
                held[d] = 1'b0;
            end else begin
                if (held[d]) begin
                    chk("hold_valid", 64'(rsp_valid[d]), 64'd1);
                    chk("hold_err", 64'(rsp_err[d]), 64'(perr[d]));
                    chk("hold_data", rd[d], pdat[d]);
                end
                if (rsp_valid[d] && !rsp_ready[d])
                    chk("stall_req_ready", 64'(req_ready[d]), 64'd0);
                if (rsp_valid[d] && rsp_ready[d]) begin
                    checks++;
                    if (qsize(d) == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp dut%0d got err=%0b data=%h expected none",
                                 d, rsp_err[d], rd[d]);
                    end else begin
                        e = qpop(d);
                        if (rsp_err[d] !== e.err || rd[d] !== e.data) begin
                            errors++;
                            $display("FAIL rsp dut%0d got err=%0b data=%h expected err=%0b data=%h",
                                     d, rsp_err[d], rd[d], e.err, e.data);
                        end
                    end
                end
                held[d] = rsp_valid[d] && !rsp_ready[d];
                perr[d] = rsp_err[d];
                pdat[d] = rd[d];
            end
        end
    end

    // Model computes the response from byte-addressed memory; a known
    // constant may override it for the directed cases.
    task automatic issue(input int d, input bit we, input int addr,
                         input logic [1:0] sz, input bit sg,
                         input logic [63:0] wd, input bit k,
                         input bit kerr, input logic [63:0] kdat);
        int nb, sb, n;
        bit err;
        logic [63:0] v;
        rsp_t r;
        nb = d ? 8 : 4;
        sb = 1 << sz;
        err = (sb > nb) || (addr % sb != 0);
        v = '0;
        if (!err && we)
            for (int i = 0; i < sb; i++) mem[d][addr+i] = wd[8*i +: 8];
        if (!err && !we) begin
            for (int i = 0; i < sb; i++) v[8*i +: 8] = mem[d][addr+i];
            if (sg && v[8*sb-1])
                for (int i = sb; i < 8; i++) v[8*i +: 8] = 8'hFF;
            if (nb == 4) v[63:32] = '0;
        end
        r.err = err;
        r.data = v;
        if (k) begin
            r.err = kerr;
            r.data = kdat;
        end
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = AW'(addr);
        req_size[d]   = sz;
        req_signed[d] = sg;
        req_wdata[d]  = wd;
        #2;
        n = 0;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!req_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d got ready=0 expected 1", d);
            req_valid[d] = 1'b0;
        end else begin
            if (d != 0) q1.push_back(r);
            else q0.push_back(r);
            @(posedge clk);
            #1;
            req_valid[d] = 1'b0;
            chk("latency_valid", 64'(rsp_valid[d]), 64'd1);
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while ((qsize(d) != 0 || rsp_valid[d]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("drain_left", 64'(qsize(d)), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("reset_valid", 64'(rsp_valid[d]), 64'd0);
            chk("reset_err", 64'(rsp_err[d]), 64'd0);
            chk("reset_rdata", rd[d], 64'd0);
            chk("reset_req_ready", 64'(req_ready[d]), 64'd1);
        end
        mode[0] = 0;
        mode[1] = 0;

        issue(0, 1, 'h20, 2'b10, 0, 64'h80FF7F01, 1, 0, 0);
        issue(0, 0, 'h23, 2'b00, 1, 0, 1, 0, 64'hFFFFFF80);
        issue(0, 0, 'h23, 2'b00, 0, 0, 1, 0, 64'h00000080);
        issue(0, 0, 'h22, 2'b01, 1, 0, 1, 0, 64'hFFFF80FF);
        issue(0, 0, 'h20, 2'b01, 0, 0, 1, 0, 64'h00007F01);
        issue(0, 1, 'h21, 2'b00, 0, 64'hAB, 1, 0, 0);
        issue(0, 0, 'h20, 2'b10, 0, 0, 1, 0, 64'h80FFAB01);
        issue(0, 1, 'h22, 2'b01, 0, 64'hBEEF, 1, 0, 0);
        issue(0, 0, 'h20, 2'b10, 0, 0, 1, 0, 64'hBEEFAB01);
        issue(0, 0, 'h23, 2'b01, 1, 0, 1, 1, 0);
        issue(0, 1, 'h22, 2'b10, 0, 64'h12345678, 1, 1, 0);
        issue(0, 0, 'h20, 2'b10, 0, 0, 1, 0, 64'hBEEFAB01);
        issue(0, 0, 'h20, 2'b11, 0, 0, 1, 1, 0);
        drain(0);

        arm[0] = 1'b1;
        issue(0, 0, 'h20, 2'b10, 0, 0, 1, 0, 64'hBEEFAB01);
        issue(0, 0, 'h20, 2'b00, 0, 0, 1, 0, 64'h01);
        issue(0, 0, 'h21, 2'b00, 0, 0, 1, 0, 64'hAB);
        issue(0, 0, 'h22, 2'b01, 0, 0, 1, 0, 64'hBEEF);
        drain(0);

        mode[0] = 2;
        issue(0, 0, 'h20, 2'b10, 0, 0, 1, 0, 64'hBEEFAB01);
        quiet = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        chk("pending_before_rst", 64'(qsize(0)), 64'd1);
        if (qsize(0) != 0) void'(qpop(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready[0]), 64'd1);
        quiet = 1'b0;
        mode[0] = 0;
        issue(0, 0, 'h20, 2'b10, 0, 0, 1, 0, 64'hBEEFAB01);
        drain(0);

        issue(1, 1, 'h08, 2'b11, 0, 64'h0123456789ABCDEF, 1, 0, 0);
        issue(1, 0, 'h08, 2'b10, 1, 0, 1, 0, 64'hFFFFFFFF89ABCDEF);
        issue(1, 0, 'h0C, 2'b10, 1, 0, 1, 0, 64'h0000000001234567);
        issue(1, 0, 'h0F, 2'b00, 0, 0, 1, 0, 64'h01);
        issue(1, 0, 'h0C, 2'b11, 0, 0, 1, 1, 0);
        drain(1);

        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 64; a += 4)
                issue(d, 1, a, 2'b10, 0, {32'h0, $urandom}, 0, 0, 0);
            mode[d] = 1;
            for (int i = 0; i < 300; i++) begin
                issue(d, 1'($urandom_range(0, 1)), $urandom_range(0, 63),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      {$urandom, $urandom}, 0, 0, 0);
                if ($urandom_range(0, 7) == 0) @(negedge clk);
            end
            mode[d] = 0;
            drain(d);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
